order_byte_serializer: RTL and testbench
========================================

Name: order_byte_serializer

Overview:
- Downstream neighbour of trading_top. Consumes the 72-bit order word trading_top drives on its order bus.
- Buffers orders in a small FIFO and emits each one as a 9-byte frame on a valid/ready byte stream, for the exchange-link transmitter.
- Drops orders on FIFO overflow and counts them, so order bursts never stall the strategy pipeline.

Parameters:
- FIFO_DEPTH, 8, number of buffered orders; power of two, >=2.
- ORDER_WIDTH, 72, order word width; must be a multiple of 8. NBYTES = ORDER_WIDTH/8 (9).
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the fifo_level port (derived).

Ports:
- clk_100mhz  in  1  system clock; all logic on the rising edge.
- global_reset_n  in  1  asynchronous, active-low reset.
- order_bus  in  ORDER_WIDTH  order word from trading_top.
- order_valid  in  1  one-cycle strobe: order_bus holds a new order.
- byte_data  out  8  current frame byte, MSB byte of the order first.
- byte_valid  out  1  byte_data is valid.
- byte_ready  in  1  downstream accepts the byte this cycle.
- byte_first  out  1  current byte is byte 0 of its frame.
- byte_last  out  1  current byte is byte NBYTES-1 of its frame.
- fifo_level  out  LVL_W  orders waiting in the FIFO; excludes the frame being sent.
- overflow  out  1  sticky: at least one order has been dropped.
- clear_overflow  in  1  synchronous clear of overflow and drop_count.
- drop_count  out  16  number of dropped orders, saturating at 16'hFFFF.

Behaviour:
- Reset: all outputs are 0 while global_reset_n is low, asynchronously. FIFO pointers, shift register, byte index and FSM return to IDLE. Any frame in progress is abandoned and never resumed.
- FIFO write: on order_valid with fifo_level < FIFO_DEPTH, order_bus is written at that edge; fifo_level reflects the write the next cycle.
- FIFO full:
  - order_valid while fifo_level == FIFO_DEPTH drops the order.
  - It sets overflow and increments drop_count.
  - "Full" is judged on the registered level, so a write is dropped even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: fifo_level is unchanged. Both actions take effect.
- FSM states:
  - IDLE: byte_valid=0. If fifo_level != 0, pop the head into the shift register, set idx=0 and go to SEND.
  - SEND: byte_valid=1, byte_data = shift[ORDER_WIDTH-1 -: 8], byte_first = (idx==0), byte_last = (idx==NBYTES-1).
    - On byte_valid & byte_ready with idx < NBYTES-1: shift left 8, idx++.
    - On byte_valid & byte_ready with idx == NBYTES-1: if the FIFO is non-empty, pop the next order into the shift register with idx=0 and stay in SEND (no bubble). Otherwise go to IDLE.
- Latency: order_valid in cycle N with the FIFO empty and FSM in IDLE gives byte_valid=1 with byte 0 in cycle N+2.
- Handshake:
  - Once byte_valid is high, byte_data, byte_first and byte_last stay stable until byte_ready is seen.
  - byte_valid never drops mid-frame.
  - The block does not depend combinationally on byte_ready for byte_valid.
- Frame throughput: with byte_ready held at 1, back-to-back orders produce continuous bytes, one frame per NBYTES cycles.
- drop_count saturates and does not wrap.
- clear_overflow takes priority over a drop in the same cycle: the result is overflow=0 and drop_count=0, and that drop is not counted.

Test Plan:
- Single order: push 72'h0123456789ABCDEF01 with byte_ready=1. Require byte_valid from cycle N+2 for 9 cycles with bytes 01,23,45,67,89,AB,CD,EF,01. byte_first only on byte 01 (the first), byte_last only on the final 01. byte_valid returns to 0 after the frame.
- Backpressure: same order with byte_ready toggling 1,0,0,1,... Require byte_data, byte_first and byte_last held while ready=0, and the same 9-byte sequence with no duplicates or skips.
- Back-to-back: push 3 orders (11..11, 22..22, 33..33) on consecutive cycles with byte_ready=1. Require 27 consecutive valid cycles, byte_last asserted at bytes 9, 18 and 27, and fifo_level peaking at 2.
- Overflow: byte_ready=0, push 10 orders on consecutive cycles with FIFO_DEPTH=8. Require the first order in the shift register, fifo_level=8, drop_count=1 and overflow=1. Then pulse clear_overflow: require overflow=0 and drop_count=0.
- Reset mid-frame: drop global_reset_n during byte 4 of a frame. Require all outputs 0 immediately, without waiting for a clock edge. After release: byte_valid=0 and fifo_level=0. A new push then yields a fresh frame starting at byte 0.
- Saturation: force 65540 drops with clear_overflow=0. Require drop_count=16'hFFFF.

Source files
------------

// File: rtl/order_byte_serializer.sv
`default_nettype none
// =============================================================================
// Module  : order_byte_serializer
// Brief   : Buffers order words in a FIFO and emits each as a byte frame on a
//           valid/ready stream; drops and counts orders when the FIFO is full.
// Revision: 1.0 - initial release
// =============================================================================
module order_byte_serializer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int ORDER_WIDTH = 72,
    parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk_100mhz,
    input  logic                   global_reset_n,
    input  logic [ORDER_WIDTH-1:0] order_bus,
    input  logic                   order_valid,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   byte_first,
    output logic                   byte_last,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic [15:0]            drop_count
);
    localparam int NBYTES = ORDER_WIDTH / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [LVL_W-1:0] c_FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ORDER_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic [ORDER_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_overflow;
    logic [15:0]            r_drop_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_advance;
    logic w_sending;

    // Fullness is judged on the registered level, so a same-cycle pop never rescues a write.
    assign w_full  = (r_level == c_FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_push  = order_valid && !w_full;
    assign w_drop  = order_valid && w_full;

    always_ff @(posedge clk_100mhz or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (byte_ready) begin
                    if (r_idx != c_LAST_IDX) begin
                        w_advance = 1'b1;
                    end else if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= order_bus;
        end
    end

    always_ff @(posedge clk_100mhz or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    always_ff @(posedge clk_100mhz or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_idx   <= '0;
        end else if (w_advance) begin
            r_shift <= r_shift << 8;
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

    // A clear in the same cycle as a drop wins; that drop is not counted.
    always_ff @(posedge clk_100mhz or negedge global_reset_n) begin
        if (!global_reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign w_sending  = (r_state == S_SEND);
    assign byte_valid = w_sending;
    assign byte_data  = w_sending ? r_shift[ORDER_WIDTH-1 -: 8] : 8'h00;
    assign byte_first = w_sending && (r_idx == '0);
    assign byte_last  = w_sending && (r_idx == c_LAST_IDX);
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_order_byte_serializer.sv
`default_nettype none
// =============================================================================
// Module  : tb_order_byte_serializer
// Brief   : Self-checking bench: queue-based reference model plus directed tests.
// Revision: 1.0 - initial release
// =============================================================================
module tb_order_byte_serializer;
    localparam int DEPTH = 8;
    localparam int OW    = 72;
    localparam int NB    = 9;
    localparam int LW    = 4;

    logic          clk_100mhz = 1'b0;
    logic          global_reset_n;
    logic [OW-1:0] order_bus;
    logic          order_valid;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic          byte_first;
    logic          byte_last;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          clear_overflow;
    logic [15:0]   drop_count;

    int n_checks = 0;
    int n_errors = 0;

    order_byte_serializer #(
        .FIFO_DEPTH (DEPTH),
        .ORDER_WIDTH(OW),
        .LVL_W      (LW)
    ) dut (
        .clk_100mhz    (clk_100mhz),
        .global_reset_n(global_reset_n),
        .order_bus     (order_bus),
        .order_valid   (order_valid),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .byte_first    (byte_first),
        .byte_last     (byte_last),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .clear_overflow(clear_overflow),
        .drop_count    (drop_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after each rising edge.
    task automatic cyc();
        @(posedge clk_100mhz);
        #2;
    endtask

    // Reference model: a queue of waiting orders and the frame currently on the wire.
    logic [OW-1:0] m_q [$];
    logic [OW-1:0] m_cur;
    bit            m_active;
    int            m_bi;
    int            m_drops;
    bit            m_ovf;
    int            m_lvl;

    always @(posedge clk_100mhz or negedge global_reset_n) begin
        if (!global_reset_n) begin
            m_q.delete();
            m_cur    = '0;
            m_active = 1'b0;
            m_bi     = 0;
            m_drops  = 0;
            m_ovf    = 1'b0;
        end else begin
            m_lvl = m_q.size();
            if (!m_active) begin
                if (m_lvl != 0) begin
                    m_cur    = m_q.pop_front();
                    m_bi     = 0;
                    m_active = 1'b1;
                end
            end else if (byte_ready) begin
                if (m_bi < NB - 1) begin
                    m_bi++;
                end else if (m_lvl != 0) begin
                    m_cur = m_q.pop_front();
                    m_bi  = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
            if (order_valid && m_lvl < DEPTH) m_q.push_back(order_bus);
            if (clear_overflow) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end else if (order_valid && m_lvl == DEPTH) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
    end

    logic [7:0] e_data;
    always @(negedge clk_100mhz) begin
        if (global_reset_n) begin
            e_data = m_active ? m_cur[OW-1-8*m_bi -: 8] : 8'h00;
            chk("cycle_outputs",
                {byte_valid, byte_first, byte_last, byte_data, fifo_level, overflow, drop_count},
                {m_active, m_active && m_bi == 0, m_active && m_bi == NB - 1, e_data,
                 LW'(m_q.size()), m_ovf, 16'(m_drops)});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp1 [9];
        logic [7:0]  acc [$];
        int          lasts [$];
        logic [10:0] prev;
        bit          prev_hold;
        int          nv, run, maxrun, peak;
        logic [7:0]  tb_byte;

        exp1 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        global_reset_n = 1'b0;
        order_bus      = '0;
        order_valid    = 1'b0;
        byte_ready     = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) cyc();
        chk("reset_outputs",
            {byte_valid, byte_first, byte_last, byte_data, fifo_level, overflow, drop_count}, '0);
        global_reset_n = 1'b1;
        cyc();

        // Single order, latency and byte order
        byte_ready  = 1'b1;
        order_bus   = 72'h0123456789ABCDEF01;
        order_valid = 1'b1;
        cyc();
        order_valid = 1'b0;
        chk("t1_not_yet_valid", byte_valid, 1'b0);
        for (int k = 0; k < NB; k++) begin
            cyc();
            chk("t1_byte", {byte_valid, byte_first, byte_last, byte_data},
                {1'b1, k == 0, k == NB - 1, exp1[k]});
        end
        cyc();
        chk("t1_idle_after", byte_valid, 1'b0);

        // Backpressure with ready pattern 1,0,0,1,0,0...
        order_valid = 1'b1;
        cyc();
        order_valid = 1'b0;
        prev_hold   = 1'b0;
        prev        = '0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            byte_ready = (k % 3 == 0);
            if (prev_hold)
                chk("t2_hold", {byte_valid, byte_first, byte_last, byte_data}, prev);
            prev      = {byte_valid, byte_first, byte_last, byte_data};
            prev_hold = byte_valid && !byte_ready;
            if (byte_valid && byte_ready) begin
                chk("t2_flags", {byte_first, byte_last}, {acc.size() == 0, acc.size() == NB - 1});
                acc.push_back(byte_data);
                if (acc.size() == NB) break;
            end
        end
        chk("t2_accept_count", acc.size(), NB);
        for (int k = 0; k < acc.size() && k < NB; k++) chk("t2_byte", acc[k], exp1[k]);
        cyc();
        byte_ready = 1'b1;
        cyc();
        chk("t2_idle_after", byte_valid, 1'b0);

        // Back-to-back frames
        nv = 0; run = 0; maxrun = 0; peak = 0;
        for (int c = 0; c < 40; c++) begin
            order_valid = (c < 3);
            tb_byte     = 8'((c + 1) * 8'h11);
            order_bus   = {9{tb_byte}};
            if (byte_valid) begin
                nv++;
                run++;
                if (run > maxrun) maxrun = run;
                if (byte_last) lasts.push_back(nv);
                if (nv == 10) chk("t3_frame2_first", {byte_first, byte_data}, {1'b1, 8'h22});
            end else begin
                run = 0;
            end
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            cyc();
        end
        order_valid = 1'b0;
        chk("t3_valid_cycles", nv, 27);
        chk("t3_max_run", maxrun, 27);
        chk("t3_fifo_peak", peak, 2);
        chk("t3_last_count", lasts.size(), 3);
        for (int i = 0; i < lasts.size() && i < 3; i++) chk("t3_last_pos", lasts[i], (i + 1) * NB);

        // Overflow: 10 orders with the sink stalled
        byte_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            order_valid = 1'b1;
            tb_byte     = 8'(8'hC0 + i);
            order_bus   = {tb_byte, 64'(i)};
            cyc();
        end
        order_valid = 1'b0;
        chk("t4_full_state", {byte_valid, byte_first, byte_data, fifo_level, overflow, drop_count},
            {1'b1, 1'b1, 8'hC0, 4'd8, 1'b1, 16'd1});
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        chk("t4_cleared", {overflow, drop_count}, {1'b0, 16'd0});
        order_valid    = 1'b1;
        clear_overflow = 1'b1;
        cyc();
        order_valid    = 1'b0;
        clear_overflow = 1'b0;
        chk("t4_clear_beats_drop", {overflow, drop_count, fifo_level}, {1'b0, 16'd0, 4'd8});
        byte_ready = 1'b1;
        repeat (100) cyc();
        chk("t4_drained", {byte_valid, fifo_level}, {1'b0, 4'd0});

        // Reset in the middle of a frame
        order_valid = 1'b1;
        order_bus   = 72'hA1A2A3A4A5A6A7A8A9;
        cyc();
        order_bus   = 72'hB1B2B3B4B5B6B7B8B9;
        cyc();
        order_valid = 1'b0;
        repeat (4) cyc();
        chk("t5_at_byte4", {byte_valid, byte_data, fifo_level}, {1'b1, 8'hA5, 4'd1});
        global_reset_n = 1'b0;
        #1;
        chk("t5_async_reset",
            {byte_valid, byte_first, byte_last, byte_data, fifo_level, overflow, drop_count}, '0);
        cyc();
        cyc();
        global_reset_n = 1'b1;
        chk("t5_after_release", {byte_valid, fifo_level}, {1'b0, 4'd0});
        cyc();
        chk("t5_still_idle", {byte_valid, fifo_level}, {1'b0, 4'd0});
        order_valid = 1'b1;
        order_bus   = 72'hC1C2C3C4C5C6C7C8C9;
        cyc();
        order_valid = 1'b0;
        cyc();
        chk("t5_fresh_frame", {byte_valid, byte_first, byte_data}, {1'b1, 1'b1, 8'hC1});
        repeat (12) cyc();

        // Drop counter saturation
        byte_ready  = 1'b0;
        order_valid = 1'b1;
        order_bus   = 72'h5A5A5A5A5A5A5A5A5A;
        repeat (9 + 65540) cyc();
        order_valid = 1'b0;
        chk("t6_saturated", {overflow, drop_count}, {1'b1, 16'hFFFF});
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
